queue_egress: RTL and testbench
===============================

Name: queue_egress

Overview:
- Read-side stage directly downstream of the queue pointer controller and its synchronous storage RAM.
- Issues pops to the controller, tracks RAM reads in flight, and captures returned data into a small output buffer.
- Presents a registered valid/ready stream to the consumer, sustaining one word per cycle with no bubbles when the consumer is always ready.

Parameters:
- W, 32, data word width.
- N, 16, queue depth in entries; power of 2; must match the controller.
- RD_LAT, 1, RAM read latency in cycles; legal values are 1 and 2.
- BUF_N, RD_LAT+1, output buffer depth in entries; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_empty_w  in  1  next-cycle empty status from the queue controller.
- o_pop  out  1  pop request to the queue controller; also the RAM read enable.
- i_rd_data  in  W  RAM read data; valid RD_LAT cycles after o_pop.
- o_valid  out  1  output word valid.
- o_data  out  W  output word; registered.
- i_ready  in  1  consumer accepts o_data.
- o_level  out  $clog2(BUF_N+1)  current output buffer occupancy.
- o_busy  out  1  high when any read is in flight or the buffer is non-empty.

Behaviour:
- Reset: one clock, one synchronous active-high reset.
  - rst is synchronous and active-high; while rst is high, state clears at every clk edge.
  - The controller's reset must be asserted over the same window.
  - Reset values: empty_r=1, inflight pipe=0, buffer pointers=0, o_valid=0, o_level=0, o_busy=0, o_pop=0.
  - o_data reset value is don't-care; it must be zeroed for lint cleanliness.
- empty_r <= i_empty_w every cycle.
  - o_pop depends only on registered state and i_ready, so there is no combinational loop through the controller.
- Credit rule:
  - outstanding = popcount(inflight) + occupancy.
  - deq = o_valid & i_ready.
  - o_pop = !rst & !empty_r & (outstanding - deq < BUF_N).
- In-flight pipe: RD_LAT-bit shift register. Bit 0 <= o_pop; bit RD_LAT-1 marks i_rd_data valid this cycle.
- Capture: when the in-flight tail bit is set, i_rd_data is written to the buffer tail at the clock edge. Buffer overflow is impossible by the credit rule; assert !(capture & full & !deq).
- Output:
  - o_valid = occupancy != 0.
  - o_data = head entry, taken from a register.
  - deq advances the head.
  - Capture and deq in the same cycle leave occupancy unchanged.
- Latency:
  - Pop at cycle t gives data on i_rd_data at t+RD_LAT.
  - o_valid rises at t+RD_LAT+1.
  - A push into an empty queue at cycle t produces o_pop at t+1.
- Ordering: words leave in pop order, with no drops and no duplicates.
- Wrap-around: buffer pointers wrap modulo BUF_N. Occupancy is tracked by a separate counter of width $clog2(BUF_N+1).
- Backpressure: while i_ready=0 and the buffer is full, o_pop stays 0. Pops resume in the same cycle i_ready returns to 1.
- o_valid, once high, stays high with o_data stable until deq.
- Reset mid-operation: in-flight reads are discarded. Data returning after reset is ignored because the in-flight pipe was cleared.
- o_level = occupancy. o_busy = |inflight | (occupancy != 0).

Test Plan:
- Reset, then hold i_empty_w=1 for 10 cycles -> o_pop=0, o_valid=0, o_level=0, o_busy=0 throughout.
- RD_LAT=1; empty_r falls at cycle 5; RAM returns 0xA5A5_0001 at cycle 6 -> o_pop=1 at 5, o_valid=1 with o_data=0xA5A5_0001 at cycle 7. With i_ready=1 at 7 -> o_valid=0 at 8.
- RD_LAT=2; queue holds 8 words 0..7; i_ready=1 constantly -> o_pop high 8 consecutive cycles; o_valid high 8 consecutive cycles with data 0..7 in order and no bubbles.
- RD_LAT=2; queue holds 8 words; i_ready=0 -> exactly 3 pops, then o_pop=0, o_level=3. Assert i_ready -> o_pop=1 the same cycle; all 8 words delivered in order.
- Alternate i_ready 1/0 every cycle over 16 words -> every word is delivered exactly once and in order; o_level never exceeds BUF_N; no capture-overflow assertion fires.
- RD_LAT=2; assert rst one cycle after a pop -> after reset o_valid=0 and o_level=0; the late RAM return is not captured; o_busy=0.

Source files
------------

// File: rtl/queue_egress.sv
// Read side of a RAM-backed queue: pops the controller under a credit limit,
// tracks RAM reads in flight, and buffers returned words into a registered valid/ready stream.
module queue_egress #(
  parameter int  W      = 32,
  parameter int  N      = 16,
  parameter int  RD_LAT = 1,
  localparam int BUF_N  = RD_LAT + 1,
  localparam int LW     = $clog2(BUF_N + 1),
  localparam int PW     = $clog2(BUF_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_empty_w,
  output logic          o_pop,
  input  logic [W-1:0]  i_rd_data,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  input  logic          i_ready,
  output logic [LW-1:0] o_level,
  output logic          o_busy
);

  if (RD_LAT < 1 || RD_LAT > 2 || N < 2 || (N & (N - 1)) != 0) begin : g_bad_param
    $error("queue_egress: RD_LAT must be 1 or 2 and N a power of 2");
  end

  logic                    empty_r;
  logic [RD_LAT-1:0]       vld_pipe;
  logic [BUF_N-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           occ;
  logic                    capture, deq, full;
  int                      outstanding;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_N - 1)) ? '0 : p + 1'b1;
  endfunction

  assign capture = vld_pipe[RD_LAT-1];
  assign deq     = o_valid & i_ready;
  assign full    = (occ == LW'(BUF_N));

  // Every pop owns a buffer slot until its word leaves, so the buffer can never overflow.
  always_comb begin
    outstanding = $countones(vld_pipe) + int'(occ);
    o_pop       = !rst && !empty_r && ((outstanding - int'(deq)) < BUF_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      empty_r  <= 1'b1;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      mem      <= '0;
    end else begin
      empty_r     <= i_empty_w;
      vld_pipe[0] <= o_pop;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (capture) begin
        mem[wr_ptr] <= i_rd_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (!rst) assert (!(capture && full && !deq));

  assign o_valid = (occ != '0);
  assign o_data  = mem[rd_ptr];
  assign o_level = occ;
  assign o_busy  = (|vld_pipe) || (occ != '0);

endmodule

// File: tb/tb_queue_egress.sv
// Drives RD_LAT=1 and RD_LAT=2 instances with shared stimulus; each has a controller/RAM
// environment and a queue-based reference of reads in flight and buffered words.
module tb_queue_egress;
  localparam int W = 32;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              ready     = 1'b1;
  logic              push      = 1'b0;
  logic [W-1:0]      push_data = '0;
  logic [1:0]        pop_v, valid_v, busy_v;
  logic [1:0][W-1:0] data_v;
  logic [1:0][1:0]   level_v;
  int                n_vec = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int LAT = k + 1;
    localparam int BN  = LAT + 1;

    logic                empty_w  = 1'b1;
    logic [W-1:0]        ram_in   = '0;
    logic [LAT-1:0][W-1:0] ram_pipe = '0;
    logic [W-1:0]        rd_data;
    logic [W-1:0]        ctl_q [$];
    logic [W-1:0]        m_buf [$];
    logic [W-1:0]        fl_word [$];
    int                  fl_due [$];
    bit                  m_empty_r = 1'b1;
    bit                  e_valid, e_deq, e_pop;
    int                  m_cyc = 0;

    queue_egress #(.W(W), .N(16), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_empty_w (empty_w),
      .o_pop     (pop_v[k]),
      .i_rd_data (rd_data),
      .o_valid   (valid_v[k]),
      .o_data    (data_v[k]),
      .i_ready   (ready),
      .o_level   (level_v[k]),
      .o_busy    (busy_v[k])
    );

    // Synchronous RAM: the word read on a pop appears LAT cycles later; filler otherwise.
    assign rd_data = ram_pipe[LAT-1];
    always @(posedge clk) begin
      ram_pipe[0] <= ram_in;
      for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    initial forever begin
      @(negedge clk);
      e_valid = m_buf.size() != 0;
      e_deq   = e_valid && ready;
      e_pop   = !rst && !m_empty_r && (fl_word.size() + m_buf.size() - int'(e_deq) < BN);
      chk($sformatf("lat%0d_pop", LAT),   32'(pop_v[k]),   32'(e_pop));
      chk($sformatf("lat%0d_valid", LAT), 32'(valid_v[k]), 32'(e_valid));
      if (e_valid) chk($sformatf("lat%0d_data", LAT), data_v[k], m_buf[0]);
      chk($sformatf("lat%0d_level", LAT), 32'(level_v[k]), 32'(m_buf.size()));
      chk($sformatf("lat%0d_busy", LAT),  32'(busy_v[k]),
          32'(fl_word.size() != 0 || m_buf.size() != 0));

      if (rst) begin
        m_buf.delete();
        fl_word.delete();
        fl_due.delete();
      end else begin
        if (e_deq) void'(m_buf.pop_front());
        while (fl_due.size() != 0 && fl_due[0] == m_cyc) begin
          m_buf.push_back(fl_word.pop_front());
          void'(fl_due.pop_front());
        end
        if (e_pop) begin
          fl_word.push_back(ctl_q.size() != 0 ? ctl_q[0] : '0);
          fl_due.push_back(m_cyc + LAT);
        end
      end

      // controller reacts to the pop the DUT actually issued
      if (rst) begin
        ctl_q.delete();
        ram_in  = $urandom;
        empty_w = 1'b1;
      end else begin
        if (pop_v[k]) begin
          chk($sformatf("lat%0d_pop_nonempty", LAT), 32'(ctl_q.size() != 0), 32'd1);
          if (ctl_q.size() != 0) ram_in = ctl_q.pop_front();
          else ram_in = $urandom;
        end else begin
          ram_in = $urandom;
        end
        if (push) ctl_q.push_back(push_data);
        empty_w = (ctl_q.size() == 0);
      end
      m_empty_r = empty_w;
      m_cyc++;
    end
  end

  initial begin
    int t0, run0, run1, best0, best1;
    bit seen;

    rst = 1'b1; ready = 1'b1; push = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_pop1", 32'(pop_v[1]), 32'd0);
      chk("idle_busy1", 32'(busy_v[1]), 32'd0);
    end

    // single word: pop the cycle after the push, valid two cycles later for RD_LAT=1
    push = 1'b1; push_data = 32'hA5A5_0001; t0 = cyc;
    tick();
    push = 1'b0;
    for (int i = 0; i < 10 && !valid_v[0]; i++) tick();
    chk("lat1_rise", 32'(cyc - t0), 32'd3);
    chk("lat1_data", data_v[0], 32'hA5A5_0001);
    tick();
    chk("lat1_fall", 32'(valid_v[0]), 32'd0);
    repeat (5) tick();

    // always-ready stream of 8 words: no bubbles on the output
    run0 = 0; run1 = 0; best0 = 0; best1 = 0;
    for (int i = 0; i < 20; i++) begin
      push = (i < 8); push_data = 32'h100 + 32'(i);
      tick();
      run0 = valid_v[0] ? run0 + 1 : 0;
      run1 = valid_v[1] ? run1 + 1 : 0;
      if (run0 > best0) best0 = run0;
      if (run1 > best1) best1 = run1;
    end
    push = 1'b0;
    chk("stream_run0", 32'(best0), 32'd8);
    chk("stream_run1", 32'(best1), 32'd8);

    // backpressure: pops stop once the buffer is claimed, resume with ready
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = 32'h200 + 32'(i);
      tick();
    end
    push = 1'b0;
    repeat (6) tick();
    chk("bp_level0", 32'(level_v[0]), 32'd2);
    chk("bp_level1", 32'(level_v[1]), 32'd3);
    chk("bp_pop1", 32'(pop_v[1]), 32'd0);
    ready = 1'b1;
    #1;
    chk("bp_resume1", 32'(pop_v[1]), 32'd1);
    repeat (20) tick();

    // alternating ready over 16 words
    for (int i = 0; i < 60; i++) begin
      push = (i < 16); push_data = 32'h300 + 32'(i);
      ready = (i % 2) == 0;
      tick();
    end
    push = 1'b0; ready = 1'b1;
    repeat (10) tick();

    // random traffic with occasional long stalls
    for (int i = 0; i < 400; i++) begin
      push      = $urandom_range(0, 99) < 55;
      push_data = $urandom;
      ready     = (i % 50 < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    push = 1'b0; ready = 1'b1;
    repeat (20) tick();

    // reset one cycle after a pop: the late RAM return must be dropped
    ready = 1'b0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      push = (i < 3); push_data = 32'hB000 + 32'(i);
      tick();
      seen = pop_v[1];
    end
    push = 1'b0;
    chk("rst_pop_seen", 32'(pop_v[1]), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid1", 32'(valid_v[1]), 32'd0);
    chk("rst_level1", 32'(level_v[1]), 32'd0);
    repeat (3) tick();
    chk("rst_late_level1", 32'(level_v[1]), 32'd0);
    chk("rst_busy1", 32'(busy_v[1]), 32'd0);

    // recovery after reset
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push = (i < 6); push_data = 32'hC000 + 32'(i);
      tick();
    end
    push = 1'b0;
    repeat (15) tick();
    chk("end_busy0", 32'(busy_v[0]), 32'd0);
    chk("end_busy1", 32'(busy_v[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
